// File: rtl/alu_ops_pkg.sv
// ---------------------------------------------------------------------------
// alu_ops_pkg
// Shared definitions for the execute stage. The ALU control decoder imports
// the same package, so the op-code values below are the contract between the
// decoder and the datapath.
//   alu_op_t            4-bit ALU operation code
//   ALU_AND .. ALU_SW   valid operation codes; 8, 13, 14 and 15 are unused
//   ALU_INVALID         canonical invalid code used by the decoder
//   ALU_DATA_WIDTH      default operand/result width (MIPS: 32)
//   ALU_REG_ADDR_WIDTH  default register index width
// ---------------------------------------------------------------------------
package alu_ops_pkg;

    localparam int ALU_DATA_WIDTH     = 32;
    localparam int ALU_REG_ADDR_WIDTH = 5;
    localparam int ALU_SHAMT_WIDTH    = 5;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_AND     = 4'd0;
    localparam alu_op_t ALU_OR      = 4'd1;
    localparam alu_op_t ALU_NOR     = 4'd2;
    localparam alu_op_t ALU_ADD     = 4'd3;
    localparam alu_op_t ALU_SUB     = 4'd4;
    localparam alu_op_t ALU_SLL     = 4'd5;
    localparam alu_op_t ALU_SRL     = 4'd6;
    localparam alu_op_t ALU_LUI     = 4'd7;
    localparam alu_op_t ALU_JAL     = 4'd9;
    localparam alu_op_t ALU_JR      = 4'd10;
    localparam alu_op_t ALU_LW      = 4'd11;
    localparam alu_op_t ALU_SW      = 4'd12;
    localparam alu_op_t ALU_INVALID = 4'd15;

endpackage

// File: rtl/ex_mem_alu_stage_if.sv
// ---------------------------------------------------------------------------
// ex_mem_alu_stage_if
// Bundles the ID/EX inputs and EX/MEM outputs of the execute stage.
//   master : pipeline side - drives Stall/Flush/ClearFault and the ID/EX
//            slot, observes the EX/MEM register
//   slave  : the execute stage itself
// Optional feature: macro ALU_OVERFLOW_EN adds the Overflow signal.
// ---------------------------------------------------------------------------
interface ex_mem_alu_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    // ID/EX side
    logic                      Stall;
    logic                      Flush;
    logic                      InValid;
    logic [3:0]                ALUOperation;
    logic [DATA_WIDTH-1:0]     A;
    logic [DATA_WIDTH-1:0]     B;
    logic [4:0]                Shamt;
    logic [DATA_WIDTH-1:0]     PCPlus4;
    logic [DATA_WIDTH-1:0]     StoreDataIn;
    logic [REG_ADDR_WIDTH-1:0] WriteRegIn;
    logic                      RegWriteIn;
    logic                      MemReadIn;
    logic                      MemWriteIn;
    logic                      ClearFault;

    // EX/MEM side
    logic                      OutValid;
    logic [DATA_WIDTH-1:0]     ALUResult;
    logic                      Zero;
    logic [DATA_WIDTH-1:0]     StoreData;
    logic [REG_ADDR_WIDTH-1:0] WriteRegOut;
    logic                      RegWriteOut;
    logic                      MemReadOut;
    logic                      MemWriteOut;
    logic                      InvalidOp;
`ifdef ALU_OVERFLOW_EN
    logic                      Overflow;
`endif

    modport master (
        output Stall, Flush, InValid, ALUOperation, A, B, Shamt, PCPlus4,
               StoreDataIn, WriteRegIn, RegWriteIn, MemReadIn, MemWriteIn,
               ClearFault,
`ifdef ALU_OVERFLOW_EN
        input  Overflow,
`endif
        input  OutValid, ALUResult, Zero, StoreData, WriteRegOut,
               RegWriteOut, MemReadOut, MemWriteOut, InvalidOp
    );

    modport slave (
        input  Stall, Flush, InValid, ALUOperation, A, B, Shamt, PCPlus4,
               StoreDataIn, WriteRegIn, RegWriteIn, MemReadIn, MemWriteIn,
               ClearFault,
`ifdef ALU_OVERFLOW_EN
        output Overflow,
`endif
        output OutValid, ALUResult, Zero, StoreData, WriteRegOut,
               RegWriteOut, MemReadOut, MemWriteOut, InvalidOp
    );

endinterface

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational MIPS ALU.
//   op        ALU operation code (alu_ops_pkg)
//   a, b      operands; b carries rt or the extended immediate
//   shamt     shift amount for SLL/SRL
//   pc_plus4  link value returned for JAL
//   result    operation result, 0 for an invalid code
//   zero      result == 0
//   invalid   op is not a defined operation code
//   overflow  signed overflow of ADD/SUB only (macro ALU_OVERFLOW_EN)
// All arithmetic wraps; nothing traps here.
// ---------------------------------------------------------------------------
module alu_core
    import alu_ops_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
    input  alu_op_t                op,
    input  logic [DATA_WIDTH-1:0]  a,
    input  logic [DATA_WIDTH-1:0]  b,
    input  logic [4:0]             shamt,
    input  logic [DATA_WIDTH-1:0]  pc_plus4,
    output logic [DATA_WIDTH-1:0]  result,
    output logic                   zero,
    output logic                   invalid
`ifdef ALU_OVERFLOW_EN
    ,
    output logic                   overflow
`endif
);

    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] diff;

    // LW/SW share the adder with ADD: the address is just A + offset.
    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        // NOTE: every output gets a default before the case, so no path
        // through the block leaves a value unassigned (no inferred latch).
        result  = '0;
        invalid = 1'b0;
        case (op)
            ALU_AND:                 result = a & b;
            ALU_OR:                  result = a | b;
            ALU_NOR:                 result = ~(a | b);
            ALU_ADD, ALU_LW, ALU_SW: result = sum;
            ALU_SUB:                 result = diff;
            ALU_SLL:                 result = b << shamt;
            ALU_SRL:                 result = b >> shamt;
            ALU_LUI:                 result = {b[15:0], {(DATA_WIDTH-16){1'b0}}};
            ALU_JAL:                 result = pc_plus4;
            ALU_JR:                  result = a;
            default:                 invalid = 1'b1;
        endcase
    end

    // An invalid code yields result 0, so zero is naturally 1 in that case.
    assign zero = (result == '0);

`ifdef ALU_OVERFLOW_EN
    // Signed overflow: operands whose signs make overflow possible, and a
    // result whose sign disagrees with A. Address adds (LW/SW) never flag.
    always_comb begin
        overflow = 1'b0;
        case (op)
            ALU_ADD: overflow = (a[MSB] == b[MSB]) && (sum[MSB]  != a[MSB]);
            ALU_SUB: overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            default: overflow = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/ex_mem_alu_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_alu_stage
// Execute stage of the pipelined MIPS core: runs the ALU on the ID/EX slot
// and captures result plus forwarded control bits in the EX/MEM register.
//   clk    system clock, rising edge
//   reset  asynchronous, active-high; clears every output
//   bus    ex_mem_alu_stage_if.slave - ID/EX inputs, Stall/Flush/ClearFault,
//          EX/MEM outputs and the sticky InvalidOp fault flag
// Per edge: Flush > Stall > load. Flush, or a load of an empty slot
// (InValid=0), writes a bubble; Stall holds everything.
// Optional feature: macro ALU_OVERFLOW_EN adds a registered Overflow flag
// and suppresses RegWriteOut on signed ADD/SUB overflow.
// ---------------------------------------------------------------------------
module ex_mem_alu_stage
    import alu_ops_pkg::*;
#(
    parameter int DATA_WIDTH     = ALU_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = ALU_REG_ADDR_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    ex_mem_alu_stage_if.slave bus
);

    typedef struct packed {
        logic                      valid;
        logic [DATA_WIDTH-1:0]     result;
        logic                      zero;
        logic [DATA_WIDTH-1:0]     store_data;
        logic [REG_ADDR_WIDTH-1:0] write_reg;
        logic                      reg_write;
        logic                      mem_read;
        logic                      mem_write;
`ifdef ALU_OVERFLOW_EN
        logic                      overflow;
`endif
    } ex_mem_t;

    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_zero;
    logic                  alu_invalid;
    logic                  alu_overflow;
    logic                  capture;
    logic                  bubble;
    ex_mem_t               ex_mem_d;
    ex_mem_t               ex_mem_q;
    logic                  invalid_op_q;

    alu_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu_core (
        .op       (bus.ALUOperation),
        .a        (bus.A),
        .b        (bus.B),
        .shamt    (bus.Shamt),
        .pc_plus4 (bus.PCPlus4),
        .result   (alu_result),
        .zero     (alu_zero),
        .invalid  (alu_invalid)
`ifdef ALU_OVERFLOW_EN
        ,
        .overflow (alu_overflow)
`endif
    );

`ifndef ALU_OVERFLOW_EN
    // Without the feature ADD/SUB never suppress the register write.
    assign alu_overflow = 1'b0;
`endif

    // Stall with Flush still bubbles; Stall alone (any InValid) holds.
    assign capture = bus.InValid & ~bus.Stall & ~bus.Flush;
    assign bubble  = bus.Flush | (~bus.Stall & ~bus.InValid);

    // Value loaded on a capture edge. An invalid op still occupies a valid
    // slot but must not write the register file or touch memory.
    always_comb begin
        ex_mem_d            = '0;
        ex_mem_d.valid      = 1'b1;
        ex_mem_d.result     = alu_result;
        ex_mem_d.zero       = alu_zero;
        ex_mem_d.store_data = bus.StoreDataIn;
        ex_mem_d.write_reg  = bus.WriteRegIn;
        ex_mem_d.reg_write  = bus.RegWriteIn & ~alu_invalid & ~alu_overflow;
        ex_mem_d.mem_read   = bus.MemReadIn  & ~alu_invalid;
        ex_mem_d.mem_write  = bus.MemWriteIn & ~alu_invalid;
`ifdef ALU_OVERFLOW_EN
        ex_mem_d.overflow   = alu_overflow;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_mem_q <= '0;
        end else if (bubble) begin
            ex_mem_q <= '0;
        end else if (capture) begin
            ex_mem_q <= ex_mem_d;
        end
    end

    // Sticky fault: a captured invalid op wins over ClearFault; a stalled or
    // flushed invalid op never sets it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            invalid_op_q <= 1'b0;
        end else if (capture && alu_invalid) begin
            invalid_op_q <= 1'b1;
        end else if (bus.ClearFault) begin
            invalid_op_q <= 1'b0;
        end
    end

    assign bus.OutValid    = ex_mem_q.valid;
    assign bus.ALUResult   = ex_mem_q.result;
    assign bus.Zero        = ex_mem_q.zero;
    assign bus.StoreData   = ex_mem_q.store_data;
    assign bus.WriteRegOut = ex_mem_q.write_reg;
    assign bus.RegWriteOut = ex_mem_q.reg_write;
    assign bus.MemReadOut  = ex_mem_q.mem_read;
    assign bus.MemWriteOut = ex_mem_q.mem_write;
    assign bus.InvalidOp   = invalid_op_q;
`ifdef ALU_OVERFLOW_EN
    assign bus.Overflow    = ex_mem_q.overflow;
`endif

endmodule
